mtm_alu_serial_param: RTL
=========================

# mtm_alu_serial_param

Synthesizable serial ALU core with parametrised operand width. Receives framed commands on a one-wire input, checks byte count, CRC4 and opcode, executes AND/OR/ADD/SUB, and returns a framed result with flags and CRC3, or a single error frame. Sits behind the pads as the DUT side of the existing serial command protocol, generalised from fixed 32-bit operands to `N_BYTES` bytes per operand.

## Interface
- `N_BYTES`, default 4: bytes per operand, legal range 1..8. Operand width W = 8*N_BYTES.
- `CRC_CHECK`, default 1: 1 = check CRC4; 0 = skip CRC4 check, so ERR_CRC is never raised.
- `clk` input, 1 bit: single clock; all logic on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `sin` input, 1 bit: serial command stream, idle 1.
- `sout` output, 1 bit: serial response stream, idle 1, registered.
- `busy` output, 1 bit: 1 from the sampled start bit of a command's first byte until the response stop bit has been driven.

## Operation
- **Frame format:** 11 bits, MSB first: start 0, type (0 = DATA, 1 = CTL), d[7:0], stop 1.
- **Receiver FSM:** IDLE → TYPE → BITS (8) → STOP → IDLE.
  - IDLE waits for `sin`==0.
  - If the stop bit is sampled 0, the byte is discarded. The command state is unchanged and no response is sent.
- **Command:** 2·N_BYTES DATA bytes (B MSB byte first, then A), then a CTL byte d = {0, op[2:0], crc4[3:0]}.
- **CRC4:** remainder of ({B, A, 1'b1, op} · x^4) mod (x^4+x+1), initial value 0.
- **CRC3:** remainder of ({C, 1'b0, flags} · x^3) mod (x^3+x+1), initial value 0.
- **Error checks** on command completion, highest priority first:
  - ERR_DATA (3'b100): a CTL byte arrives with data count ≠ 2·N_BYTES, or a DATA byte arrives when the count is already 2·N_BYTES. The error is raised immediately on that byte. The count is then cleared and the next DATA byte starts a new command.
  - ERR_CRC (3'b010): crc4 mismatch.
  - ERR_OP (3'b001): op not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
- **Arithmetic:** W+1-bit internal result, C = low W bits.
- **Flags {carry, overflow, zero, negative}:**
  - carry = bit W of the result. For SUB this is the borrow (B < A unsigned). Always 0 for AND/OR.
  - overflow: ADD = (B[msb]==A[msb]) && (C[msb]≠B[msb]); SUB = (B[msb]≠A[msb]) && (C[msb]≠B[msb]); 0 for AND/OR.
  - zero = (C==0); negative = C[msb].
- **OK response:** N_BYTES DATA bytes of C (MSB byte first), then CTL byte {0, flags[3:0], crc3[2:0]}.
- **Error response:** one CTL byte {1, err[2:0], err[2:0], p}, where p makes the 8-bit byte even parity.
- **Buffering:** the result and response type are captured into a holding register at command completion. TX serialises from that register. The receiver keeps running during TX. Protocol length (response ≤ command) guarantees no overrun; a completion while TX is busy is not required to be handled.
- **Reset values:** `sout`=1, `busy`=0, receiver in IDLE, data count 0, holding register cleared, TX idle.

## Timing
- `sin` is sampled on every rising edge of `clk`, one bit per clock (the driver updates on the falling edge).
- The response start bit appears on `sout` at the 2nd rising edge after the edge that sampled the final CTL stop bit. For ERR_DATA raised by an extra DATA byte, the same rule applies to that byte's stop bit.
- Response bytes are back-to-back with no idle bits between them. OK response = 11·(N_BYTES+1) clocks; error response = 11 clocks.
- `busy` falls on the edge after the last stop bit is driven.
- Reset asserted mid-command or mid-response: `sout` goes to 1 immediately and the partial command is lost. The first command after release must be processed normally.

## Test plan
All values with N_BYTES=4 unless stated.
- ADD, B=0xFFFFFFFF, A=0x00000001, valid CRC → C=0x00000000, flags=4'b1010, correct crc3, 5 bytes.
- SUB, B=0, A=1 → C=0xFFFFFFFF, flags=4'b1001. Then AND, B=0xF0F0F0F0, A=0xFF00FF00 → C=0xF000F000, flags=4'b0001.
- Valid frame with crc4+1 → single byte 0xA5. Op 3'b010 with correct CRC → 0x93.
- 9 DATA bytes, no CTL → 0xC9 after the 9th byte. A following valid command → correct result.
- N_BYTES=2: ADD, B=0x7FFF, A=0x0001 → C=0x8000, flags=4'b0101, 3-byte response.
- `rst_n` pulsed low during the 4th response byte → `sout`=1 and `busy`=0 at once. Then a back-to-back OR command → correct response with 2-cycle latency.

Source files
------------

// File: rtl/mtm_alu_serial_param.sv
// Serial ALU core: receives framed operand/control bytes on sin, checks the
// command (byte count, CRC4, opcode), executes AND/OR/ADD/SUB on
// 8*N_BYTES-bit operands and returns either a data+status response or a
// single error byte on sout.
module mtm_alu_serial_param #(
   parameter int N_BYTES   = 4,
   parameter bit CRC_CHECK = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sin,
   output logic sout,
   output logic busy
);

   localparam int W     = 8 * N_BYTES;
   localparam int DW    = 2 * W;
   localparam int CNT_W = $clog2(2 * N_BYTES + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(2 * N_BYTES);

   typedef enum logic [1:0] {RX_IDLE, RX_TYPE, RX_BITS, RX_STOP} rx_state_t;

   // ---------------------------------------------------------------- receiver
   rx_state_t        rx_state_reg;
   logic             rx_type_reg;
   logic [7:0]       rx_byte_reg;
   logic [2:0]       rx_bit_reg;
   logic [CNT_W-1:0] data_cnt_reg;
   logic [DW-1:0]    data_sr_reg;     // {B, A}, B arrives first
   logic [6:0]       ctl_reg;         // {op, crc4} of the last CTL byte
   logic             done_reg;        // one-cycle pulse: command complete
   logic             err_data_reg;    // completion was a framing/count error

   // Deserialise frames and track the operand byte count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_reg <= RX_IDLE;
         rx_type_reg  <= 1'b0;
         rx_byte_reg  <= '0;
         rx_bit_reg   <= '0;
         data_cnt_reg <= '0;
         data_sr_reg  <= '0;
         ctl_reg      <= '0;
         done_reg     <= 1'b0;
         err_data_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               if (!sin) rx_state_reg <= RX_TYPE;
            end
            RX_TYPE: begin
               rx_type_reg  <= sin;
               rx_bit_reg   <= '0;
               rx_state_reg <= RX_BITS;
            end
            RX_BITS: begin
               rx_byte_reg <= {rx_byte_reg[6:0], sin};
               rx_bit_reg  <= rx_bit_reg + 3'd1;
               if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
            end
            RX_STOP: begin
               rx_state_reg <= RX_IDLE;
               // A broken stop bit drops the byte without touching command state
               if (sin) begin
                  if (!rx_type_reg) begin
                     if (data_cnt_reg == FULL_CNT) begin
                        done_reg     <= 1'b1;
                        err_data_reg <= 1'b1;
                        data_cnt_reg <= '0;
                     end else begin
                        data_sr_reg  <= {data_sr_reg[DW-9:0], rx_byte_reg};
                        data_cnt_reg <= data_cnt_reg + CNT_W'(1);
                     end
                  end else begin
                     done_reg     <= 1'b1;
                     ctl_reg      <= rx_byte_reg[6:0];
                     err_data_reg <= (data_cnt_reg != FULL_CNT);
                     data_cnt_reg <= '0;
                  end
               end
            end
            default: rx_state_reg <= RX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- execute
   logic [W-1:0] opnd_b, opnd_a;
   logic [2:0]   op;
   logic [W:0]   res;
   logic         ovf;
   logic [3:0]   flags;
   logic [2:0]   err;
   logic         op_valid;

   assign opnd_b = data_sr_reg[DW-1:W];
   assign opnd_a = data_sr_reg[W-1:0];
   assign op     = ctl_reg[6:4];

   // CRC4 over {B, A, 1, op}: unrolled Galois LFSR, poly x^4+x+1
   logic [DW+3:0] crc4_msg;
   logic [3:0]    crc4_chain [DW+5];
   assign crc4_msg      = {data_sr_reg, 1'b1, op};
   assign crc4_chain[0] = 4'd0;
   for (genvar gi = 0; gi < DW + 4; gi++) begin : g_crc4
      logic fb;
      assign fb = crc4_chain[gi][3] ^ crc4_msg[DW+3-gi];
      assign crc4_chain[gi+1] = {crc4_chain[gi][2:0], 1'b0} ^ {2'b00, fb, fb};
   end

   // CRC3 over {C, 0, flags}: unrolled Galois LFSR, poly x^3+x+1
   logic [W+4:0] crc3_msg;
   logic [2:0]   crc3_chain [W+6];
   assign crc3_msg      = {res[W-1:0], 1'b0, flags};
   assign crc3_chain[0] = 3'd0;
   for (genvar gi = 0; gi < W + 5; gi++) begin : g_crc3
      logic fb;
      assign fb = crc3_chain[gi][2] ^ crc3_msg[W+4-gi];
      assign crc3_chain[gi+1] = {crc3_chain[gi][1:0], 1'b0} ^ {1'b0, fb, fb};
   end

   // Compute result, flags and error code from the captured command
   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (op)
         3'b000:  res = {1'b0, opnd_b & opnd_a};
         3'b001:  res = {1'b0, opnd_b | opnd_a};
         3'b100: begin
            res = {1'b0, opnd_b} + {1'b0, opnd_a};
            ovf = (opnd_b[W-1] == opnd_a[W-1]) && (res[W-1] != opnd_b[W-1]);
         end
         3'b101: begin
            res = {1'b0, opnd_b} - {1'b0, opnd_a};
            ovf = (opnd_b[W-1] != opnd_a[W-1]) && (res[W-1] != opnd_b[W-1]);
         end
         default: res = '0;
      endcase
      flags    = {res[W], ovf, (res[W-1:0] == '0), res[W-1]};
      op_valid = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
      if (err_data_reg)
         err = 3'b100;
      else if (CRC_CHECK && (crc4_chain[DW+4] != ctl_reg[3:0]))
         err = 3'b010;
      else if (!op_valid)
         err = 3'b001;
      else
         err = 3'b000;
   end

   // ---------------------------------------------------------------- transmit
   logic [W-1:0] hold_c_reg;
   logic [7:0]   hold_ctl_reg;
   logic         hold_err_reg;
   logic         tx_active_reg;
   logic [3:0]   tx_byte_reg;
   logic [3:0]   tx_bit_reg;
   logic         tx_done_reg;

   logic [7:0]   c_bytes [N_BYTES];
   for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_cbytes
      assign c_bytes[gi] = hold_c_reg[W-1-8*gi -: 8];
   end

   logic        cur_last;
   logic [7:0]  cur_d;
   logic [10:0] frame;

   // Select the frame currently being shifted out
   always_comb begin
      cur_last = hold_err_reg || (tx_byte_reg == 4'(N_BYTES));
      cur_d    = hold_ctl_reg;
      if (!cur_last) begin
         for (int k = 0; k < N_BYTES; k++) begin
            if (tx_byte_reg == 4'(k)) cur_d = c_bytes[k];
         end
      end
      frame = {1'b0, cur_last, cur_d, 1'b1};
   end

   // Capture the response, serialise it and maintain busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_c_reg    <= '0;
         hold_ctl_reg  <= '0;
         hold_err_reg  <= 1'b0;
         tx_active_reg <= 1'b0;
         tx_byte_reg   <= '0;
         tx_bit_reg    <= '0;
         tx_done_reg   <= 1'b0;
         sout          <= 1'b1;
         busy          <= 1'b0;
      end else begin
         tx_done_reg <= 1'b0;
         if (done_reg) begin
            hold_c_reg    <= res[W-1:0];
            hold_err_reg  <= (err != 3'b000);
            hold_ctl_reg  <= (err != 3'b000) ? {1'b1, err, err, ^{1'b1, err, err}}
                                             : {1'b0, flags, crc3_chain[W+5]};
            tx_active_reg <= 1'b1;
            tx_byte_reg   <= '0;
            tx_bit_reg    <= '0;
         end else if (tx_active_reg) begin
            sout <= frame[4'd10 - tx_bit_reg];
            if (tx_bit_reg == 4'd10) begin
               tx_bit_reg <= '0;
               if (cur_last) begin
                  tx_active_reg <= 1'b0;
                  tx_done_reg   <= 1'b1;
               end else begin
                  tx_byte_reg <= tx_byte_reg + 4'd1;
               end
            end else begin
               tx_bit_reg <= tx_bit_reg + 4'd1;
            end
         end
         // busy drops after the response unless another command is under way
         if (tx_done_reg && rx_state_reg == RX_IDLE && data_cnt_reg == '0)
            busy <= 1'b0;
         if (rx_state_reg == RX_STOP && !sin && data_cnt_reg == '0 &&
             !tx_active_reg && !done_reg)
            busy <= 1'b0;
         if (rx_state_reg == RX_IDLE && !sin)
            busy <= 1'b1;
      end
   end

endmodule
